// File: rtl/pipe_ctrl_pkg.sv
// Shared types and control patterns for the pipeline stall/flush controller.
// Bit i of every pause/flush vector addresses stage STG_*.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DIV_WAIT,
    ST_MEM_WAIT
  } state_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam logic [4:0] PAUSE_MEM  = 5'b01111;
  localparam logic [4:0] FLUSH_MEM  = 5'b10000;
  localparam logic [4:0] PAUSE_DIV  = 5'b00111;
  localparam logic [4:0] FLUSH_DIV  = 5'b01000;
  localparam logic [4:0] FLUSH_BR   = 5'b00111;
  localparam logic [4:0] PAUSE_LU   = 5'b00011;
  localparam logic [4:0] FLUSH_LU   = 5'b00100;
  localparam logic [4:0] FLUSH_TRAP = 5'b01111;

endpackage

// File: rtl/ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources read in ID.
// x0 is never a real dependency.
module ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Priority: trap, memory wait, divide, branch, load-use.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_div_start,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        trap,
  input  logic [31:0] trap_vec,
  output logic [4:0]  pause,
  output logic [4:0]  flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        div_done,
  output logic [31:0] stall_cnt
);

  localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  state_e      state_q, state_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic        trap_pending_q, trap_pending_d;
  logic [31:0] trap_vec_q, trap_vec_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        load_use;
  logic        eff_trap;
  logic [31:0] eff_vec;
  logic        mem_hold;
  logic        div_hold;

  ctrl_hazard_detect u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // A trap seen during a memory wait is replayed with its captured vector.
  assign eff_trap = trap | trap_pending_q;
  assign eff_vec  = trap_pending_q ? trap_vec_q : trap_vec;
  assign mem_hold = (state_q == ST_MEM_WAIT) && !mem_ack;
  assign div_hold = (state_q == ST_DIV_WAIT) && !trap &&
                    (div_cnt_q != '0);

  always_comb begin
    state_d        = state_q;
    div_cnt_d      = div_cnt_q;
    trap_pending_d = trap_pending_q;
    trap_vec_d     = trap_vec_q;
    pause          = '0;
    flush          = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    div_done       = 1'b0;
    if (!rst) begin
      if (mem_hold) begin
        pause = PAUSE_MEM;
        flush = FLUSH_MEM;
        if (trap && !trap_pending_q) begin
          trap_pending_d = 1'b1;
          trap_vec_d     = trap_vec;
        end
      end else if (div_hold) begin
        pause     = PAUSE_DIV;
        flush     = FLUSH_DIV;
        div_cnt_d = div_cnt_q - CW'(1);
      end else begin
        state_d        = ST_RUN;
        trap_pending_d = 1'b0;
        div_done       = (state_q == ST_DIV_WAIT) && !eff_trap;
        if (eff_trap) begin
          redirect_valid = 1'b1;
          redirect_pc    = eff_vec;
          flush          = FLUSH_TRAP;
          div_cnt_d      = '0;
        end else if (mem_req && !mem_ack) begin
          pause   = PAUSE_MEM;
          flush   = FLUSH_MEM;
          state_d = ST_MEM_WAIT;
        end else if (ex_div_start && (state_q != ST_DIV_WAIT)) begin
          pause     = PAUSE_DIV;
          flush     = FLUSH_DIV;
          div_cnt_d = CW'(DIV_CYCLES - 2);
          state_d   = ST_DIV_WAIT;
        end else if (ex_branch_taken) begin
          redirect_valid = 1'b1;
          redirect_pc    = ex_branch_target;
          flush          = FLUSH_BR;
        end else if (load_use) begin
          pause = PAUSE_LU;
          flush = FLUSH_LU;
        end
      end
    end
    stall_cnt_d = stall_cnt_q + {31'd0, |pause};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      div_cnt_q      <= '0;
      trap_pending_q <= 1'b0;
      trap_vec_q     <= '0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      trap_pending_q <= trap_pending_d;
      trap_vec_q     <= trap_vec_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
